// File: rtl/capture_buffer_reader.sv
// Drains the multi-channel capture buffer as framed bytes: SYNC, channel id, samples, checksum.
// Every output is registered. The read address is a running counter because channels are stored back to back.
//
// state | meaning
// IDLE  | waiting for start
// SYNC  | offering SYNC_BYTE
// CHID  | offering channel id byte
// RADDR | read strobe out for the current sample
// RWAIT | memory data returning, folded into checksum
// DATA  | offering sample byte
// CSUM  | offering channel checksum
module capture_buffer_reader #(
    parameter int                NUM_CHANNELS = 7,
    parameter int                SAMPLES      = 10,
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 7,
    parameter logic [DATA_W-1:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_CHID,
        S_RADDR,
        S_RWAIT,
        S_DATA,
        S_CSUM
    } state_t;

    localparam logic [3:0] CH_LAST  = 4'(NUM_CHANNELS - 1);
    localparam logic [7:0] SMP_LAST = 8'(SAMPLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        ch_q, ch_d;
    logic [7:0]        smp_q, smp_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              xfer;
    logic [DATA_W-1:0] ch_byte;

    assign xfer    = out_valid_q & out_ready;
    assign ch_byte = {{(DATA_W-4){1'b0}}, ch_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            smp_q       <= '0;
            csum_q      <= '0;
            next_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            smp_q       <= smp_d;
            csum_q      <= csum_d;
            next_addr_q <= next_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        smp_d       = smp_q;
        csum_d      = csum_q;
        next_addr_d = next_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_d        = '0;
                    next_addr_d = '0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = SYNC_BYTE;
                    state_d     = S_SYNC;
                end
            end
            S_SYNC: begin
                if (xfer) begin
                    csum_d     = ch_byte;
                    out_data_d = ch_byte;
                    state_d    = S_CHID;
                end
            end
            S_CHID: begin
                if (xfer) begin
                    smp_d       = '0;
                    out_valid_d = 1'b0;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = next_addr_q;
                    next_addr_d = next_addr_q + ADDR_W'(1);
                    state_d     = S_RADDR;
                end
            end
            S_RADDR: begin
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                out_data_d  = rd_data;
                csum_d      = csum_q + rd_data;
                out_valid_d = 1'b1;
                state_d     = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    if (smp_q == SMP_LAST) begin
                        out_data_d = csum_q;
                        state_d    = S_CSUM;
                    end else begin
                        smp_d       = smp_q + 8'd1;
                        out_valid_d = 1'b0;
                        rd_en_d     = 1'b1;
                        rd_addr_d   = next_addr_q;
                        next_addr_d = next_addr_q + ADDR_W'(1);
                        state_d     = S_RADDR;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (ch_q == CH_LAST) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        ch_d       = ch_q + 4'd1;
                        out_data_d = SYNC_BYTE;
                        state_d    = S_SYNC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_capture_buffer_reader.sv
// Bench for capture_buffer_reader: randomized memory and downstream stalls, checked against a frame model.
module tb_capture_buffer_reader;

    localparam int NCH   = 7;
    localparam int NS    = 10;
    localparam int FRAME = NS + 3;
    localparam int TOTAL = NCH * FRAME;
    localparam int BOUND = 4000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, rd_en, out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    capture_buffer_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    logic [7:0] mem [0:127];
    always @(posedge clk) if (rd_en === 1'b1) rd_data <= mem[rd_addr];

    // ready_mode: 0 = always ready, 1 = random, 2 = never ready
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else                 out_ready = (ready_mode == 0);
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         rd_log[$];
    int         cyc = 0, rd_multi = 0, stall_viol = 0, follow_viol = 0, done_cnt = 0;
    bit         prev_stalled = 0, rd_prev = 0, pend_v = 0;
    logic [7:0] prev_data = 8'h00;
    int         pend_due = 0, pend_addr = 0;

    always @(negedge clk) begin
        cyc++;
        if (pend_v && cyc == pend_due) begin
            pend_v = 0;
            if (!(out_valid === 1'b1 && out_data === mem[pend_addr])) follow_viol++;
        end
        if (prev_stalled && !(out_valid === 1'b1 && out_data === prev_data)) stall_viol++;
        if (out_valid === 1'b1 && out_ready === 1'b1 && !reset) got.push_back(out_data);
        if (rd_en === 1'b1) begin
            rd_log.push_back(int'(rd_addr));
            if (rd_prev) rd_multi++;
            pend_v    = 1;
            pend_due  = cyc + 2;
            pend_addr = int'(rd_addr);
        end
        rd_prev = (rd_en === 1'b1);
        if (done === 1'b1) done_cnt++;
        prev_stalled = (out_valid === 1'b1) && (out_ready !== 1'b1);
        prev_data    = out_data;
        if (reset) begin
            prev_stalled = 0;
            pend_v       = 0;
            rd_prev      = 0;
        end
    end

    // Expected dump, built straight from the frame definition.
    task automatic build_exp();
        int sum;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(c));
            sum = c;
            for (int s = 0; s < NS; s++) begin
                exp_q.push_back(mem[c*NS + s]);
                sum += int'(mem[c*NS + s]);
            end
            exp_q.push_back(8'(sum % 256));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (rd_addr !== 7'd0)   begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        @(posedge clk); #1 reset = 1'b0;
        tick(3);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_basic();
        int n, mism, d0;
        for (int a = 0; a < 128; a++) mem[a] = 8'(a);
        build_exp();
        ready_mode = 0;
        tick(2);
        got.delete();
        d0 = done_cnt;
        pulse_start();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || busy !== 1'b1)
            begin errors++; $display("FAIL basic_first_sync: valid=%b data=%h busy=%b want 1 a5 1", out_valid, out_data, busy); end
        wait_done(n);
        checks++; if (n != 231) begin errors++; $display("FAIL basic_done_latency: got %0d want 231", n); end
        tick(3);
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done_count: got %0d want %0d", done_cnt - d0, 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        checks++; if (got.size() != TOTAL) begin errors++; $display("FAIL basic_byte_count: got %0d want %0d", got.size(), TOTAL); end
        mism = 0;
        for (int i = 0; i < TOTAL; i++) if (i >= got.size() || got[i] !== exp_q[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL basic_stream: %0d bytes differ, want 0", mism); end
        checks++; if (got[12] !== 8'h2D) begin errors++; $display("FAIL basic_ch0_csum: got %h want 2d", got[12]); end
        checks++; if (got[78] !== 8'hA5 || got[79] !== 8'h06 || got[80] !== 8'h3C)
            begin errors++; $display("FAIL basic_ch6_head: got %h %h %h want a5 06 3c", got[78], got[79], got[80]); end
    endtask

    task automatic test_random_stall();
        int n, mism, d0;
        for (int a = 0; a < 128; a++) mem[a] = 8'(a);
        build_exp();
        ready_mode = 1;
        stall_viol = 0;
        got.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(n);
        checks++; if (n >= BOUND) begin errors++; $display("FAIL stall_timeout: waited %0d cycles, want done", n); end
        ready_mode = 0;
        tick(3);
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0); end
        checks++; if (got.size() != TOTAL) begin errors++; $display("FAIL stall_byte_count: got %0d want %0d", got.size(), TOTAL); end
        mism = 0;
        for (int i = 0; i < TOTAL; i++) if (i >= got.size() || got[i] !== exp_q[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL stall_stream: %0d bytes differ, want 0", mism); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: %0d unstable stalls, want 0", stall_viol); end
    endtask

    task automatic test_csum_wrap();
        int n, mism;
        for (int a = 0; a < 128; a++) mem[a] = 8'hFF;
        build_exp();
        ready_mode = 0;
        got.delete();
        pulse_start();
        wait_done(n);
        tick(3);
        checks++; if (got[12] !== 8'hF6) begin errors++; $display("FAIL wrap_ch0_csum: got %h want f6", got[12]); end
        checks++; if (got[3*FRAME + 12] !== 8'hF9) begin errors++; $display("FAIL wrap_ch3_csum: got %h want f9", got[3*FRAME + 12]); end
        mism = 0;
        for (int i = 0; i < TOTAL; i++) if (i >= got.size() || got[i] !== exp_q[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL wrap_stream: %0d bytes differ, want 0", mism); end
    endtask

    task automatic test_start_while_busy();
        int n, mism, d0;
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
        build_exp();
        ready_mode = 0;
        got.delete();
        rd_log.delete();
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (rd_log.size() < 2*NS + 2 && n < BOUND) begin @(negedge clk); n++; end
        ready_mode = 2;
        while (out_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        pulse_start();
        tick(1);
        ready_mode = 0;
        wait_done(n);
        checks++; if (n >= BOUND) begin errors++; $display("FAIL busy_start_timeout: waited %0d cycles, want done", n); end
        tick(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued: busy=%b want 0", busy); end
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt - d0); end
        checks++; if (got.size() != TOTAL) begin errors++; $display("FAIL busy_start_byte_count: got %0d want %0d", got.size(), TOTAL); end
        mism = 0;
        for (int i = 0; i < TOTAL; i++) if (i >= got.size() || got[i] !== exp_q[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL busy_start_stream: %0d bytes differ, want 0", mism); end
    endtask

    task automatic test_reset_mid_dump();
        int n, mism, d0;
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
        build_exp();
        ready_mode = 0;
        rd_log.delete();
        d0 = done_cnt;
        pulse_start();
        n = 0;
        while (rd_log.size() < 4*NS + 3 && n < BOUND) begin @(negedge clk); n++; end
        ready_mode = 2;
        while (out_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        tick(2);
        checks++; if (out_valid !== 1'b1 || out_data !== mem[4*NS + 2])
            begin errors++; $display("FAIL abort_stalled_data: valid=%b data=%h want 1 %h", out_valid, out_data, mem[4*NS + 2]); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, rd_en, out_valid} !== 4'b0000 || rd_addr !== 7'd0 || out_data !== 8'h00)
            begin errors++; $display("FAIL abort_outputs: busy=%b done=%b rd_en=%b valid=%b addr=%0d data=%h want all 0",
                                     busy, done, rd_en, out_valid, rd_addr, out_data); end
        ready_mode = 0;
        tick(5);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
        got.delete();
        rd_log.delete();
        pulse_start();
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5)
            begin errors++; $display("FAIL abort_restart_sync: valid=%b data=%h want 1 a5", out_valid, out_data); end
        wait_done(n);
        tick(3);
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL abort_done_count: got %0d want 1", done_cnt - d0); end
        checks++; if (rd_log.size() == 0 || rd_log[0] != 0) begin errors++; $display("FAIL abort_restart_addr: want first address 0"); end
        mism = 0;
        for (int i = 0; i < TOTAL; i++) if (i >= got.size() || got[i] !== exp_q[i]) mism++;
        checks++; if (mism != 0 || got.size() != TOTAL)
            begin errors++; $display("FAIL abort_restart_stream: %0d differ, %0d bytes, want 0 and %0d", mism, got.size(), TOTAL); end
    endtask

    task automatic test_rd_port();
        int n, mism;
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
        build_exp();
        ready_mode = 1;
        got.delete();
        rd_log.delete();
        rd_multi = 0;
        follow_viol = 0;
        pulse_start();
        wait_done(n);
        ready_mode = 0;
        tick(3);
        checks++; if (rd_log.size() != NCH*NS) begin errors++; $display("FAIL rd_pulse_count: got %0d want %0d", rd_log.size(), NCH*NS); end
        mism = 0;
        for (int i = 0; i < NCH*NS; i++) if (i >= rd_log.size() || rd_log[i] != i) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL rd_addr_order: %0d out of order, want 0", mism); end
        checks++; if (rd_multi != 0) begin errors++; $display("FAIL rd_single_cycle: %0d long pulses, want 0", rd_multi); end
        checks++; if (follow_viol != 0) begin errors++; $display("FAIL rd_followed_by_byte: %0d misses, want 0", follow_viol); end
        mism = 0;
        for (int i = 0; i < TOTAL; i++) if (i >= got.size() || got[i] !== exp_q[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL rd_stream: %0d bytes differ, want 0", mism); end
    endtask

    initial begin
        void'($urandom(32'd20240611));
        test_reset();
        test_basic();
        test_random_stall();
        test_csum_wrap();
        test_start_while_busy();
        test_reset_mid_dump();
        test_rd_port();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
